// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the shared-adder arbiter.
// Sizes, index-width derivation and packed-lane addressing.
package adder_share_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_base(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain WIDTH-bit combinational adder.
// Carry-out is dropped; the sum wraps modulo 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_share_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins.
// Grant is one-hot; idx is its encoded position.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One shared adder, round-robin granted, with a single
// registered result slot under valid/ready backpressure.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic                     resp_valid_out,
  output logic [WIDTH-1:0]         resp_sum_out,
  output logic [ID_W-1:0]          resp_id_out,
  input  logic                     resp_ready_in
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             slot_free;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] op_a, op_b, add_sum;

  assign slot_free = !valid_q || resp_ready_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (req_valid_in),
    .ptr (ptr_q),
    .en  (slot_free),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign gnt_any = |gnt;

  // Only the granted lane is selected, so ungranted X never reaches the slot.
  assign op_a = req_a_in[lane_base(int'(gnt_idx), WIDTH) +: WIDTH];
  assign op_b = req_b_in[lane_base(int'(gnt_idx), WIDTH) +: WIDTH];

  adder #(.WIDTH(WIDTH)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (gnt_any) begin
      valid_d = 1'b1;
      sum_d   = add_sum;
      id_d    = gnt_idx;
      if (int'(gnt_idx) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + ID_W'(1);
      end
    end else if (resp_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign req_ready_out  = gnt;
  assign resp_valid_out = valid_q;
  assign resp_sum_out   = sum_q;
  assign resp_id_out    = id_q;

endmodule
